trace_framer: RTL and testbench

TRACE_FRAMER -- requirements
Module: trace_framer

---
 rtl/trace_framer_pkg.sv | 33 +++
 rtl/trace_framer.sv | 172 +++++++++++++++++
 tb/tb_trace_framer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_framer_pkg.sv
// Shared definitions for the trace framer: FSM encoding, header defaults and
// the byte offsets of each section within a frame.
package trace_framer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StSend,
        StWait,
        StNext,
        StDone
    } state_e;

    localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
    localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PT_OFS  = 11'd2;
    localparam cnt_t KEY_OFS = 11'd6;
    localparam cnt_t CT_OFS  = 11'd14;
    localparam cnt_t TR_OFS  = 11'd18;

    // Byte 'pos' of a word counted from the most significant byte.
    function automatic logic [7:0] msb_byte(input logic [63:0] word, input logic [2:0] pos);
        logic [63:0] shifted;
        shifted = word << {pos, 3'b000};
        return shifted[63:56];
    endfunction

endpackage

// File: rtl/trace_framer.sv
// Streams one capture frame (headers, pt/key/ct, trace memory, checksum) to a
// byte-wide UART transmitter, one byte per tx_start/tx_done handshake.
module trace_framer
    import trace_framer_pkg::*;
#(
    parameter int unsigned SAMPLES = 1024,
    parameter logic [7:0]  HDR0    = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1    = HDR1_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pt,
    input  logic [63:0] key,
    input  logic [31:0] ct,
    output logic [9:0]  trace_addr,
    input  logic [7:0]  trace_data,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic        busy,
    output logic        done
);

    localparam cnt_t CHK_IDX = cnt_t'(TR_OFS + SAMPLES);

    state_e      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] pt_q, pt_d;
    logic [63:0] key_q, key_d;
    logic [31:0] ct_q, ct_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [9:0]  trace_addr_q, trace_addr_d;
    logic        tx_start_q, tx_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  sel_byte;
    cnt_t        cnt_nxt;
    logic [9:0]  addr_nxt;

    always_comb begin
        if (cnt_q == '0) begin
            sel_byte = HDR0;
        end else if (cnt_q < PT_OFS) begin
            sel_byte = HDR1;
        end else if (cnt_q < KEY_OFS) begin
            sel_byte = msb_byte({pt_q, 32'h0}, 3'(cnt_q - PT_OFS));
        end else if (cnt_q < CT_OFS) begin
            sel_byte = msb_byte(key_q, 3'(cnt_q - KEY_OFS));
        end else if (cnt_q < TR_OFS) begin
            sel_byte = msb_byte({ct_q, 32'h0}, 3'(cnt_q - CT_OFS));
        end else if (cnt_q < CHK_IDX) begin
            sel_byte = trace_data;
        end else begin
            sel_byte = chk_q;
        end
    end

    // The address for the following byte goes out while in NEXT so the memory's
    // one-cycle latency is already covered by the time FETCH samples trace_data.
    always_comb begin
        cnt_nxt = cnt_q + 11'd1;
        if (cnt_nxt >= TR_OFS && cnt_nxt < CHK_IDX) begin
            addr_nxt = 10'(cnt_nxt - TR_OFS);
        end else begin
            addr_nxt = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        chk_d        = chk_q;
        pt_d         = pt_q;
        key_d        = key_q;
        ct_d         = ct_q;
        tx_byte_d    = tx_byte_q;
        trace_addr_d = trace_addr_q;
        tx_start_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    pt_d    = pt;
                    key_d   = key;
                    ct_d    = ct;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d        = '0;
                chk_d        = '0;
                trace_addr_d = '0;
                state_d      = StFetch;
            end
            StFetch: begin
                tx_byte_d  = sel_byte;
                tx_start_d = 1'b1;
                state_d    = StSend;
            end
            StSend: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    trace_addr_d = addr_nxt;
                    state_d      = StNext;
                end
            end
            StNext: begin
                if (cnt_q >= PT_OFS && cnt_q < CHK_IDX) begin
                    chk_d = chk_q + tx_byte_q;
                end
                if (cnt_q == CHK_IDX) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_nxt;
                    state_d = StFetch;
                end
            end
            StDone: begin
                busy_d       = 1'b0;
                trace_addr_d = '0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            chk_q        <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            ct_q         <= '0;
            tx_byte_q    <= '0;
            trace_addr_q <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chk_q        <= chk_d;
            pt_q         <= pt_d;
            key_q        <= key_d;
            ct_q         <= ct_d;
            tx_byte_q    <= tx_byte_d;
            trace_addr_q <= trace_addr_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign trace_addr = trace_addr_q;
    assign tx_start   = tx_start_q;
    assign tx_byte    = tx_byte_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_trace_framer.sv
// Directed bench for trace_framer: full-size frames against a UART/memory model
// plus a four-sample instance for the short-frame case.
`timescale 1ns/1ps
module tb_trace_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [31:0] pt, ct;
    logic [63:0] key;
    logic [9:0]  trace_addr;
    logic [7:0]  trace_data;
    logic        tx_start, tx_done, busy, done;
    logic [7:0]  tx_byte;

    logic        start4;
    logic [9:0]  trace_addr4;
    logic [7:0]  trace_data4;
    logic        tx_start4, tx_done4, busy4, done4;
    logic [7:0]  tx_byte4;

    trace_framer dut (
        .clk(clk), .rst(rst), .start(start), .pt(pt), .key(key), .ct(ct),
        .trace_addr(trace_addr), .trace_data(trace_data), .tx_start(tx_start),
        .tx_byte(tx_byte), .tx_done(tx_done), .busy(busy), .done(done)
    );

    trace_framer #(.SAMPLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .pt(32'h0), .key(64'h0), .ct(32'h0),
        .trace_addr(trace_addr4), .trace_data(trace_data4), .tx_start(tx_start4),
        .tx_byte(tx_byte4), .tx_done(tx_done4), .busy(busy4), .done(done4)
    );

    logic [7:0] mem [1024];
    logic [7:0] head [18];

    always @(posedge clk) trace_data <= mem[trace_addr];
    always @(posedge clk) trace_data4 <= (trace_addr4 < 10'd4) ? 8'hFF : 8'h00;

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] cap [$];
    logic [7:0] cap4 [$];
    int tx_cnt, stable_err, busy_err, max_gap, done_cnt, gap, dly, spur_dly, spur_at;
    int d4, done4_cnt;
    bit in_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART model for the full-size instance: tx_done two cycles after tx_start,
    // optional stray tx_done landing in FETCH, plus busy/gap/stability monitors.
    initial begin
        tx_done = 1'b0; dly = 0; spur_dly = 0; gap = 0; in_frame = 0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                dly = 0; spur_dly = 0; in_frame = 0;
            end else begin
                gap++;
                if (start && !busy) begin
                    in_frame = 1; gap = 0;
                end else if (in_frame && !busy) begin
                    busy_err++;
                end
                if (spur_dly != 0) begin
                    spur_dly--;
                    if (spur_dly == 0) tx_done = 1'b1;
                end
                if (tx_start) begin
                    cap.push_back(tx_byte);
                    tx_cnt++;
                    if (gap > max_gap) max_gap = gap;
                    dly = 2;
                end else if (dly != 0) begin
                    if (tx_byte !== cap[cap.size()-1]) stable_err++;
                    dly--;
                    if (dly == 0) begin
                        tx_done = 1'b1;
                        gap = 0;
                        if (tx_cnt == spur_at) spur_dly = 2;
                    end
                end
                if (done) begin
                    done_cnt++; in_frame = 0;
                end
            end
        end
    end

    initial begin
        tx_done4 = 1'b0; d4 = 0;
        forever begin
            @(negedge clk);
            tx_done4 = 1'b0;
            if (rst) begin
                d4 = 0;
            end else begin
                if (tx_start4) begin
                    cap4.push_back(tx_byte4); d4 = 2;
                end else if (d4 != 0) begin
                    d4--;
                    if (d4 == 0) tx_done4 = 1'b1;
                end
                if (done4) done4_cnt++;
            end
        end
    end

    task automatic run_frame(input logic [31:0] p, input logic [63:0] k, input logic [31:0] c,
                             input int restart_at, input int stop_at);
        bit fired;
        int cyc;
        fired = 0; cyc = 0;
        cap.delete(); tx_cnt = 0; stable_err = 0; busy_err = 0; max_gap = 0; done_cnt = 0;
        pt = p; key = k; ct = c;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        // Inputs change after acceptance; the frame must carry the latched values.
        pt = ~p; key = ~k; ct = ~c;
        while (done_cnt == 0 && tx_cnt != stop_at && cyc < 12000) begin
            @(posedge clk); #1;
            cyc++;
            if (restart_at > 0 && tx_cnt == restart_at && !fired) begin
                start = 1'b1; fired = 1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("frame_in_time", 32'(cyc < 12000), 1);
        if (stop_at < 0) repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input bit zero_trace, input logic [7:0] exp_chk);
        int errs;
        logic [7:0] last, exp_b;
        errs = 0;
        last = 8'hxx;
        if (cap.size() > 0) last = cap[cap.size()-1];
        if (cap.size() != 1043) errs++;
        for (int i = 0; i < cap.size() && i < 1042; i++) begin
            if (i < 18) exp_b = head[i];
            else exp_b = zero_trace ? 8'h00 : 8'(i - 18);
            if (cap[i] !== exp_b) errs++;
        end
        check({name, "_len"}, cap.size(), 1043);
        check({name, "_first"}, (cap.size() > 0) ? cap[0] : 8'hxx, 8'hA5);
        check({name, "_bytes_err"}, errs, 0);
        check({name, "_chk"}, last, exp_chk);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_drop"}, busy_err, 0);
        check({name, "_gap_le3"}, 32'(max_gap <= 3), 1);
        check({name, "_byte_stable_err"}, stable_err, 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int cyc, errs;
        head = '{8'hA5, 8'h5A, 8'h65, 8'h65, 8'h68, 8'h77, 8'h19, 8'h18, 8'h11,
                 8'h10, 8'h09, 8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rst = 1'b1; start = 1'b0; start4 = 1'b0; spur_at = -1;
        pt = '0; key = '0; ct = '0;
        tx_cnt = 0; stable_err = 0; busy_err = 0; max_gap = 0; done_cnt = 0; done4_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_start", tx_start, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_tx_byte", tx_byte, 0);
        check("reset_trace_addr", trace_addr, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_frame(32'h65656877, 64'h1918111009080100, 32'h0, 0, -1);
        check_frame("ramp", 1'b0, 8'h0D);

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        run_frame(32'h65656877, 64'h1918111009080100, 32'h0, 0, -1);
        check_frame("zero", 1'b1, 8'h0D);

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        run_frame(32'h65656877, 64'h1918111009080100, 32'h0, 100, -1);
        check_frame("restart", 1'b0, 8'h0D);
        check("restart_tx_pulses", tx_cnt, 1043);

        spur_at = 300;
        run_frame(32'h65656877, 64'h1918111009080100, 32'h0, 0, -1);
        spur_at = -1;
        check_frame("spurious", 1'b0, 8'h0D);

        run_frame(32'h65656877, 64'h1918111009080100, 32'h0, 0, 500);
        check("abort_reached", tx_cnt, 500);
        rst = 1'b1;
        #1;
        check("abort_tx_start", tx_start, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_trace_addr", trace_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_more_tx", tx_cnt, 500);
        check("abort_no_done", done_cnt, 0);
        run_frame(32'h65656877, 64'h1918111009080100, 32'h0, 0, -1);
        check_frame("after_abort", 1'b0, 8'h0D);

        cap4.delete(); done4_cnt = 0; cyc = 0;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        while (done4_cnt == 0 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (10) @(posedge clk);
        #1;
        errs = 0;
        for (int i = 0; i < cap4.size() && i < 22; i++) begin
            if (i == 0) begin
                if (cap4[i] !== 8'hA5) errs++;
            end else if (i == 1) begin
                if (cap4[i] !== 8'h5A) errs++;
            end else if (i < 18) begin
                if (cap4[i] !== 8'h00) errs++;
            end else if (cap4[i] !== 8'hFF) begin
                errs++;
            end
        end
        check("small_len", cap4.size(), 23);
        check("small_bytes_err", errs, 0);
        check("small_chk", (cap4.size() > 0) ? cap4[cap4.size()-1] : 8'hxx, 8'hFC);
        check("small_done_pulses", done4_cnt, 1);
        check("small_busy_after", busy4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
